alu_op_sequencer: RTL and testbench
===================================

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
- REQ-001: Parameter WIDTH, default 8, operand/result width.
- REQ-002: Parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
- REQ-003: Parameter TAGW, default 4, command tag width.
- REQ-004: clk  input  1  single clock; all state on rising edge.
- REQ-005: rst  input  1  asynchronous, active-high reset.
- REQ-006: cmd_valid  input  1  command offered.
- REQ-007: cmd_ready  output  1  FIFO can accept a command.
- REQ-008: cmd_opcode  input  4  ALU opcode (ADD=0, SUB=1, AND=2, OR=3, ROL=4, SEQ=5).
- REQ-009: cmd_a, cmd_b  input  WIDTH  operands.
- REQ-010: cmd_shift  input  5  shift amount.
- REQ-011: cmd_chain  input  1  replace cmd_a with the last good result.
- REQ-012: cmd_tag  input  TAGW  returned with the response.
- REQ-013: opcode, input1, input2, shiftValue  output  4/WIDTH/WIDTH/5  registered drive to the combinational ALU.
- REQ-014: result, carryFlag, zeroFlag, overFlowFlag  input  WIDTH/1/1/1  ALU outputs.
- REQ-015: rsp_valid  output  1; rsp_ready  input  1  response handshake.
- REQ-016: rsp_result  output  WIDTH; rsp_flags  output  3  {carry, zero, overflow}; rsp_err  output  1; rsp_tag  output  TAGW.

Function
- REQ-017: A command SHALL be accepted when cmd_valid && cmd_ready; cmd_ready SHALL equal FIFO-not-full, independent of cmd_valid.
- REQ-018: FSM states SHALL be IDLE, DRIVE, SAMPLE, RESP.
- REQ-019: IDLE -> DRIVE when the FIFO is non-empty: pop the head, register opcode/operands onto the ALU drive outputs.
- REQ-020: DRIVE -> SAMPLE unconditionally (one settle cycle with drive outputs held stable).
- REQ-021: SAMPLE SHALL capture result and flags into response registers, assert rsp_valid, and go to RESP.
- REQ-022: RESP SHALL hold every rsp_* output stable until rsp_valid && rsp_ready; then go to IDLE.
- REQ-023: Latency: command accepted into an empty FIFO in an idle block at edge N SHALL produce rsp_valid high after edge N+4; throughput is one response per 4 cycles with rsp_ready held high.
- REQ-024: Drive outputs SHALL keep their last value in IDLE, SAMPLE and RESP.
- REQ-025: With cmd_chain=1, input1 SHALL be last_result instead of cmd_a.
- REQ-026: last_result SHALL be updated in SAMPLE only when rsp_err=0.
- REQ-027: Opcode > 5 SHALL skip ALU drive (drive outputs unchanged), give rsp_err=1, rsp_result=0, rsp_flags=0, tag preserved, same latency.
- REQ-028: FIFO full: cmd_ready=0; a push while full SHALL be ignored and no entry is lost or overwritten.
- REQ-029: Simultaneous push and pop on a full FIFO SHALL be permitted only as a pop; cmd_ready stays low that cycle.
- REQ-030: FIFO pointers SHALL wrap modulo DEPTH; commands are executed in acceptance order.
- REQ-031: Flags SHALL be passed through from the ALU unmodified; the sequencer performs no arithmetic.

Reset
- REQ-032: rst SHALL asynchronously force: FSM=IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, all rsp_* outputs 0, opcode/input1/input2/shiftValue 0, last_result 0.
- REQ-033: Reset mid-operation SHALL discard the in-flight command and all queued commands without producing a response.

Structure
- REQ-034: Opcode constants, FSM state encoding and the flag bit order SHALL live in shared package alu_pkg.
- REQ-035: The command queue SHALL be a sub-module alu_cmd_fifo (parameters WIDTH, DEPTH); everything else is in alu_op_sequencer.

Verification
- REQ-036: ADD a=0x7F b=0x01 -> rsp_result=0x80, flags {0,0,1}, rsp_err=0, rsp_valid after 4 cycles.
- REQ-037: SUB a=0x05 b=0x05 -> rsp_result=0x00, zero flag=1; then chained ADD b=0x03 -> rsp_result=0x03.
- REQ-038: Push 5 commands with rsp_ready=0 -> cmd_ready low after the FIFO fills; raise rsp_ready -> all responses return in order with tags 0..4.
- REQ-039: opcode=9, tag=0xA -> rsp_err=1, rsp_result=0, rsp_tag=0xA, ALU drive outputs unchanged; the next chained command still uses the prior good result.
- REQ-040: Hold rsp_ready=0 for 10 cycles in RESP -> rsp_* stable; assert rst in DRIVE -> all outputs 0 and no response afterward.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode constants, sequencer state encoding and response flag layout.
//   Used by alu_op_sequencer and its testbench.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_ROL = 4'd4;
    localparam logic [3:0] OP_SEQ = 4'd5;

    // Bit positions inside rsp_flags: {carry, zero, overflow}
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE,
        RESP
    } state_e;

    function automatic logic op_valid(input logic [3:0] op);
        return op <= OP_SEQ;
    endfunction

    function automatic logic [2:0] pack_flags(input logic c, input logic z, input logic v);
        logic [2:0] f;
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry command queue, WIDTH bits per entry, async active-high reset.
//   push/din write an entry unless full; pop removes the head shown on dout unless empty.
//   full/empty report occupancy.
module alu_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic [AW:0]      cnt;
    logic             wr, rd;

    // A push while full is dropped even if a pop happens the same cycle.
    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign full  = cnt == (AW+1)'(DEPTH);
    assign empty = cnt == '0;
    assign dout  = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(wr);
            rp  <= rp + AW'(rd);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= din;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: queues ALU commands and runs each through an external combinational ALU.
//   cmd_*   : valid/ready command input (opcode, operands, shift, chain, tag)
//   opcode/input1/input2/shiftValue : registered ALU drive
//   result/carryFlag/zeroFlag/overFlowFlag : ALU outputs sampled one settle cycle later
//   rsp_*   : valid/ready response (result, {carry,zero,overflow}, err, tag)
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shift,
    input  logic             cmd_chain,
    input  logic [TAGW-1:0]  cmd_tag,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    output logic [4:0]       shiftValue,
    input  logic [WIDTH-1:0] result,
    input  logic             carryFlag,
    input  logic             zeroFlag,
    input  logic             overFlowFlag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [2:0]       rsp_flags,
    output logic             rsp_err,
    output logic [TAGW-1:0]  rsp_tag
);
    localparam int EW = 4 + 2*WIDTH + 5 + 1 + TAGW;

    state_e          state;
    logic [EW-1:0]   head;
    logic            full, empty, pop, pend, cur_err;
    logic [TAGW-1:0] cur_tag;
    logic [WIDTH-1:0] last_result;
    logic [3:0]       h_op;
    logic [WIDTH-1:0] h_a, h_b;
    logic [4:0]       h_sh;
    logic             h_chain;
    logic [TAGW-1:0]  h_tag;

    assign cmd_ready = !full;
    assign {h_op, h_a, h_b, h_sh, h_chain, h_tag} = head;

    // pend delays issue by one cycle after a command lands in an empty queue,
    // fixing accept-to-response latency at four edges.
    assign pop = state == IDLE && pend && !empty;

    alu_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_valid && !full),
        .din   ({cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_chain, cmd_tag}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= 1'b0;
            cur_err     <= 1'b0;
            cur_tag     <= '0;
            last_result <= '0;
            opcode      <= '0;
            input1      <= '0;
            input2      <= '0;
            shiftValue  <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_flags   <= '0;
            rsp_err     <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            pend <= !empty;
            case (state)
                IDLE: if (pop) begin
                    state   <= DRIVE;
                    cur_tag <= h_tag;
                    cur_err <= !op_valid(h_op);
                    // Illegal opcodes leave the ALU drive untouched.
                    if (op_valid(h_op)) begin
                        opcode     <= h_op;
                        input1     <= h_chain ? last_result : h_a;
                        input2     <= h_b;
                        shiftValue <= h_sh;
                    end
                end
                DRIVE: state <= SAMPLE;
                SAMPLE: begin
                    state      <= RESP;
                    rsp_valid  <= 1'b1;
                    rsp_tag    <= cur_tag;
                    rsp_err    <= cur_err;
                    rsp_result <= cur_err ? '0 : result;
                    rsp_flags  <= cur_err ? '0 : pack_flags(carryFlag, zeroFlag, overFlowFlag);
                    if (!cur_err) last_result <= result;
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks of alu_op_sequencer against a queue-level model.
module tb_alu_op_sequencer;
    localparam int W = 8;
    localparam int D = 4;
    localparam int T = 4;

    logic         clk = 0, rst = 1;
    logic         cmd_valid = 0, cmd_ready;
    logic [3:0]   cmd_opcode = 0;
    logic [W-1:0] cmd_a = 0, cmd_b = 0;
    logic [4:0]   cmd_shift = 0;
    logic         cmd_chain = 0;
    logic [T-1:0] cmd_tag = 0;
    logic [3:0]   opcode;
    logic [W-1:0] input1, input2, result;
    logic [4:0]   shiftValue;
    logic         carryFlag, zeroFlag, overFlowFlag;
    logic         rsp_valid, rsp_ready = 0;
    logic [W-1:0] rsp_result;
    logic [2:0]   rsp_flags;
    logic         rsp_err;
    logic [T-1:0] rsp_tag;

    int checks = 0, errors = 0, cyc = 0;
    logic done = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .DEPTH(D), .TAGW(T)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shift(cmd_shift),
        .cmd_chain(cmd_chain), .cmd_tag(cmd_tag), .opcode(opcode), .input1(input1),
        .input2(input2), .shiftValue(shiftValue), .result(result), .carryFlag(carryFlag),
        .zeroFlag(zeroFlag), .overFlowFlag(overFlowFlag), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .rsp_tag(rsp_tag)
    );

    // Environment ALU; returns {carry, zero, overflow, result}.
    function automatic logic [W+2:0] alu(input logic [3:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic [4:0] sh);
        logic [W:0]     s;
        logic [W-1:0]   r;
        logic [2*W-1:0] rr;
        logic           c, v;
        c = 0; v = 0; r = '0; s = '0; rr = '0;
        case (op)
            4'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[W-1:0]; c = s[W]; v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]); end
            4'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[W-1:0]; c = s[W]; v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: begin rr = {a, a} << (sh % W); r = rr[2*W-1:W]; end
            4'd5: r = (a == b) ? W'(1) : W'(0);
            default: r = '0;
        endcase
        return {c, r == '0, v, r};
    endfunction

    assign {carryFlag, zeroFlag, overFlowFlag, result} = alu(opcode, input1, input2, shiftValue);

    typedef struct packed {
        logic [W-1:0] res;
        logic [2:0]   flags;
        logic         err;
        logic [T-1:0] tag;
        logic [3:0]   op;
        logic [W-1:0] in1;
        logic [W-1:0] in2;
        logic [4:0]   sh;
    } rec_t;

    rec_t exp_q[$], obs_q[$];
    int   obs_cyc[$];
    logic [W-1:0] m_last, m_in1, m_in2;
    logic [3:0]   m_op;
    logic [4:0]   m_sh;
    rec_t         e_m;
    logic [W+2:0] y_m;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model: every accepted command is executed in order; an illegal opcode
    // answers with err and leaves the drive and last good result alone.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete(); obs_q.delete(); obs_cyc.delete();
            m_last = '0; m_op = '0; m_in1 = '0; m_in2 = '0; m_sh = '0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                if (cmd_opcode > 4'd5) begin
                    e_m = '{res: '0, flags: '0, err: 1'b1, tag: cmd_tag, op: m_op, in1: m_in1, in2: m_in2, sh: m_sh};
                end else begin
                    m_op  = cmd_opcode;
                    m_in1 = cmd_chain ? m_last : cmd_a;
                    m_in2 = cmd_b;
                    m_sh  = cmd_shift;
                    y_m   = alu(m_op, m_in1, m_in2, m_sh);
                    m_last = y_m[W-1:0];
                    e_m = '{res: y_m[W-1:0], flags: y_m[W+2:W], err: 1'b0, tag: cmd_tag, op: m_op, in1: m_in1, in2: m_in2, sh: m_sh};
                end
                exp_q.push_back(e_m);
            end
            if (rsp_valid && rsp_ready) begin
                obs_q.push_back('{res: rsp_result, flags: rsp_flags, err: rsp_err, tag: rsp_tag,
                                  op: opcode, in1: input1, in2: input2, sh: shiftValue});
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        exp_q.delete(); obs_q.delete(); obs_cyc.delete();
    endtask

    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, input logic ch, input logic [T-1:0] tg);
        logic ok;
        ok = 0;
        cmd_valid = 1; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_shift = sh; cmd_chain = ch; cmd_tag = tg;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        cmd_valid = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL send_timeout got no cmd_ready want accept tag %h", tg); end
    endtask

    task automatic wait_obs(input int n);
        for (int i = 0; i < 600 && obs_q.size() < n; i++) tick(1);
    endtask

    task automatic test_reset();
        rst = 1; tick(2);
        checks++;
        if ({rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag} !== '0) begin
            errors++; $display("FAIL reset_rsp got %h want 0", {rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag});
        end
        checks++;
        if ({opcode, input1, input2, shiftValue} !== '0) begin
            errors++; $display("FAIL reset_drive got %h want 0", {opcode, input1, input2, shiftValue});
        end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
        rst = 0; tick(2);
        checks++;
        if ({cmd_ready, rsp_valid} !== 2'b10) begin errors++; $display("FAIL post_reset got %b want 10", {cmd_ready, rsp_valid}); end
    endtask

    task automatic test_add_latency();
        int lat;
        lat = 0;
        rsp_ready = 1; clear();
        send(4'd0, 8'h7F, 8'h01, 5'd0, 1'b0, 4'h1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (rsp_valid) begin lat = i; break; end
        end
        tick(2);
        checks++;
        if (lat != 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++;
        if (obs_q.size() != 1) begin errors++; $display("FAIL add_count got %0d want 1", obs_q.size()); end
        else begin
            checks++;
            if ({obs_q[0].res, obs_q[0].flags, obs_q[0].err, obs_q[0].tag} !== {8'h80, 3'b001, 1'b0, 4'h1}) begin
                errors++; $display("FAIL add_rsp got %h want %h", {obs_q[0].res, obs_q[0].flags, obs_q[0].err, obs_q[0].tag}, {8'h80, 3'b001, 1'b0, 4'h1});
            end
        end
    endtask

    task automatic test_sub_chain();
        clear();
        send(4'd1, 8'h05, 8'h05, 5'd0, 1'b0, 4'h2); wait_obs(1);
        send(4'd0, 8'hEE, 8'h03, 5'd0, 1'b1, 4'h3); wait_obs(2); tick(1);
        checks++;
        if (obs_q[0].res !== 8'h00 || obs_q[0].flags[1] !== 1'b1) begin
            errors++; $display("FAIL sub_zero got res %h flags %b want res 00 zero 1", obs_q[0].res, obs_q[0].flags);
        end
        checks++;
        if (obs_q[1].res !== 8'h03 || obs_q[1].in1 !== 8'h00) begin
            errors++; $display("FAIL chain_add got res %h in1 %h want 03 00", obs_q[1].res, obs_q[1].in1);
        end
    endtask

    task automatic test_error();
        clear();
        send(4'd0, 8'h10, 8'h20, 5'd2, 1'b0, 4'h4); wait_obs(1);
        send(4'd9, 8'h55, 8'h66, 5'd7, 1'b1, 4'hA); wait_obs(2);
        send(4'd0, 8'h99, 8'h01, 5'd0, 1'b1, 4'hB); wait_obs(3); tick(1);
        checks++;
        if ({obs_q[1].err, obs_q[1].res, obs_q[1].flags, obs_q[1].tag} !== {1'b1, 8'h00, 3'b000, 4'hA}) begin
            errors++; $display("FAIL err_rsp got %h want %h", {obs_q[1].err, obs_q[1].res, obs_q[1].flags, obs_q[1].tag}, {1'b1, 8'h00, 3'b000, 4'hA});
        end
        checks++;
        if ({obs_q[1].op, obs_q[1].in1, obs_q[1].in2, obs_q[1].sh} !== {4'd0, 8'h10, 8'h20, 5'd2}) begin
            errors++; $display("FAIL err_drive got %h want %h", {obs_q[1].op, obs_q[1].in1, obs_q[1].in2, obs_q[1].sh}, {4'd0, 8'h10, 8'h20, 5'd2});
        end
        checks++;
        if ({obs_q[2].err, obs_q[2].res} !== {1'b0, 8'h31}) begin
            errors++; $display("FAIL err_chain got %h want 031", {obs_q[2].err, obs_q[2].res});
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] snap;
        logic        ok;
        rsp_ready = 0; clear();
        for (int i = 0; i < 5; i++) send(4'd0, W'(3*i), W'(i), 5'd0, 1'b0, T'(i));
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", cmd_ready); end
        cmd_valid = 1; cmd_opcode = 0; cmd_a = 8'hAA; cmd_b = 8'h01; cmd_chain = 0; cmd_tag = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_hold got %b want 0", cmd_ready); end
        end
        snap = {rsp_result, rsp_flags, rsp_err, rsp_tag};
        checks++;
        if ({rsp_valid, snap} !== {1'b1, 8'h00, 3'b010, 1'b0, 4'h0}) begin
            errors++; $display("FAIL full_first got %h want %h", {rsp_valid, snap}, {1'b1, 8'h00, 3'b010, 1'b0, 4'h0});
        end
        ok = 1;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || {rsp_result, rsp_flags, rsp_err, rsp_tag} !== snap) ok = 0;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL resp_stable got %h want %h", {rsp_result, rsp_flags, rsp_err, rsp_tag}, snap); end
        @(posedge clk); #1;
        cmd_valid = 0; rsp_ready = 1;
        wait_obs(5); tick(20);
        checks++;
        if (obs_q.size() != 5) begin errors++; $display("FAIL full_count got %0d want 5", obs_q.size()); end
        for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
            checks++;
            if ({obs_q[i].tag, obs_q[i].res} !== {T'(i), W'(4*i)}) begin
                errors++; $display("FAIL full_order got %h want %h", {obs_q[i].tag, obs_q[i].res}, {T'(i), W'(4*i)});
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_ready = 1; clear();
        for (int i = 0; i < 4; i++) send(4'd2, W'($urandom), W'($urandom), 5'd0, 1'b0, T'(i));
        wait_obs(4); tick(1);
        for (int k = 1; k < 4 && k < obs_cyc.size(); k++) begin
            checks++;
            if (obs_cyc[k] - obs_cyc[k-1] != 4) begin
                errors++; $display("FAIL throughput got %0d want 4", obs_cyc[k] - obs_cyc[k-1]);
            end
        end
    endtask

    task automatic test_rst_drive();
        rsp_ready = 1; clear();
        send(4'd3, 8'hF0, 8'h0F, 5'd3, 1'b0, 4'h5);
        send(4'd0, 8'h01, 8'h02, 5'd0, 1'b0, 4'h6);
        @(posedge clk); #1;
        rst = 1; #1;
        checks++;
        if ({rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag, opcode, input1, input2, shiftValue, cmd_ready} !== {{(1+W+3+1+T+4+2*W+5){1'b0}}, 1'b1}) begin
            errors++; $display("FAIL rst_drive got %h want 1", {rsp_valid, rsp_result, rsp_flags, rsp_err, rsp_tag, opcode, input1, input2, shiftValue, cmd_ready});
        end
        tick(2); rst = 0; tick(30);
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL rst_discard got %0d want 0", obs_q.size()); end
        send(4'd0, 8'h44, 8'h07, 5'd0, 1'b1, 4'h7); wait_obs(1); tick(1);
        checks++;
        if (obs_q[0].res !== 8'h07) begin errors++; $display("FAIL rst_last got %h want 07", obs_q[0].res); end
    endtask

    task automatic test_random();
        clear(); done = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [3:0] op;
                    tick($urandom_range(0, 2));
                    op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
                    send(op, W'($urandom), W'($urandom), 5'($urandom), 1'($urandom_range(0, 1)), T'(i));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    rsp_ready = $urandom_range(0, 3) != 0;
                    tick(1);
                end
            end
        join
        rsp_ready = 1;
        wait_obs(exp_q.size()); tick(2);
        checks++;
        if (obs_q.size() != 40 || exp_q.size() != 40) begin
            errors++; $display("FAIL rand_count got %0d/%0d want 40", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_rsp[%0d] got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_sub_chain();
        test_error();
        test_fifo_full();
        test_back_to_back();
        test_rst_drive();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
